// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the ID-stage hazard scoreboard.
// Also provides a register-number to one-hot helper.
package hazard_scoreboard_pkg;

  localparam int REG_W           = 5;
  localparam int NUM_REGS        = 32;
  localparam int MAX_PENDING_DEF = 4;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: tracks long-latency destination registers in flight,
// and stalls issue on RAW/WAW hazards or when too many writes are outstanding.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_PENDING = MAX_PENDING_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_long,
  input  logic             flush,
  input  logic             cmp_valid,
  input  logic [4:0]       cmp_rd,
  output logic             stall_id,
  output logic             issue,
  output logic [31:0]      busy,
  output logic [3:0]       pending_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_spurious
);

  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [3:0]          cnt_nxt;
  logic                raw;
  logic                waw;
  logic                full;
  logic                cmp_hit;
  logic                cmp_spurious;
  logic                do_set;

  // A completing register counts as free this cycle: MEM/WB forwarding covers it.
  always_comb begin
    clr_vec = '0;
    if (cmp_valid && (cmp_rd != REG_X0)) clr_vec = reg_onehot(cmp_rd);
  end

  assign eff_busy = busy & ~clr_vec;

  assign raw  = (id_rs1_used && eff_busy[id_rs1]) ||
                (id_rs2_used && eff_busy[id_rs2]);
  assign waw  = id_reg_write && (id_rd != REG_X0) && eff_busy[id_rd];
  assign full = id_long && id_reg_write &&
                (pending_cnt == 4'(MAX_PENDING)) && !cmp_valid;

  assign stall_id = id_valid && !flush && (raw || waw || full);
  assign issue    = id_valid && !flush && !stall_id;

  always_comb begin
    set_vec = '0;
    if (issue && id_long && id_reg_write && (id_rd != REG_X0)) set_vec = reg_onehot(id_rd);
  end

  assign do_set       = |set_vec;
  assign cmp_hit      = cmp_valid && (cmp_rd != REG_X0) && busy[cmp_rd];
  assign cmp_spurious = cmp_valid && !cmp_hit;

  // Set wins over clear for the same register.
  assign busy_nxt = (busy & ~clr_vec) | set_vec;

  always_comb begin
    cnt_nxt = pending_cnt;
    if (do_set && !cmp_hit) begin
      cnt_nxt = pending_cnt + 4'd1;
    end else if (!do_set && cmp_hit && (pending_cnt != 4'd0)) begin
      cnt_nxt = pending_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= '0;
      pending_cnt  <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
      if (cmp_spurious) err_spurious <= 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_id),
    .count (stall_cycles)
  );

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register scoreboard for the in-order pipeline, at the ID stage. The EX-stage forwarding unit consumes results that are already in EX/MEM or MEM/WB. This block covers the producer side of those results. It tracks destination registers of long-latency instructions (loads, divides) that are still in flight. It asserts a stall at issue until every source and destination register the ID instruction needs is free, and it caps the number of outstanding long operations.

## Interface
- `MAX_PENDING`, default 4: maximum in-flight long-latency writes; legal range 1..15.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: an instruction is present in ID.
- `id_rs1`, `id_rs2` in 5: ID source register numbers.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in 5: ID destination register.
- `id_reg_write` in 1: the ID instruction writes `id_rd`.
- `id_long` in 1: the ID instruction is long-latency and its write is tracked.
- `flush` in 1: the ID instruction is being squashed this cycle.
- `cmp_valid` in 1: a long operation completes its writeback this cycle.
- `cmp_rd` in 5: register written by that completion.
- `stall_id` out 1: hold PC and IF/ID, and inject a bubble into ID/EX.
- `issue` out 1: the ID instruction advances this cycle.
- `busy` out 32: registered busy vector; bit 0 always 0.
- `pending_cnt` out 4: number of outstanding tracked writes.
- `stall_cycles` out CNT_W: saturating count of stalled cycles.
- `err_spurious` out 1: sticky flag; set by a completion for a non-busy register.

## Operation
- `clr_vec`: one-hot of `cmp_rd` when `cmp_valid` is high and `cmp_rd` is not 0; otherwise 0.
- `eff_busy` = `busy` & ~`clr_vec`. A completing register is treated as free in the same cycle, because the MEM/WB forward path supplies its value.
- `raw` = (`id_rs1_used` and `eff_busy[id_rs1]`) or (`id_rs2_used` and `eff_busy[id_rs2]`).
- `waw` = `id_reg_write` and `id_rd` is not 0 and `eff_busy[id_rd]`.
- `full` = `id_long` and `id_reg_write` and `pending_cnt` == `MAX_PENDING` and `cmp_valid` is low.
- `stall_id` = `id_valid` and not `flush` and (`raw` or `waw` or `full`).
- `issue` = `id_valid` and not `flush` and not `stall_id`.
- `set_vec`: one-hot of `id_rd` when `issue`, `id_long` and `id_reg_write` are all high and `id_rd` is not 0; otherwise 0.
- Busy next state: `busy` = (`busy` & ~`clr_vec`) | `set_vec`. If the same register is cleared and set in one cycle, the set wins and the bit stays 1.
- Count next state: `pending_cnt` += (set_vec ≠ 0) − (clr_vec ≠ 0 and the register was busy). Simultaneous set and clear leaves the count unchanged. The count never underflows.
- A completion for a non-busy register, or for x0, sets `err_spurious`. Such a completion has no effect on `busy` or the count. `err_spurious` clears only on reset.
- `stall_cycles` increments on every cycle with `stall_id` high and saturates at all-ones.
- `flush` never clears busy bits; operations already in flight still complete.
- Register x0 is never tracked.

## Timing
- Reset (asynchronous, `rst_n` low): `busy`, `pending_cnt`, `stall_cycles` and `err_spurious` go to 0. `stall_id` and `issue` are then purely combinational from inputs and zeroed state.
- `stall_id` and `issue` are combinational in the same cycle. There is no registered latency from inputs to the stall decision.
- A set becomes visible in `busy` one cycle after issue. A dependent instruction in ID the following cycle therefore stalls.
- A completion releases the stall in the same cycle it arrives. The busy bit drops at the next edge.
- Reset asserted mid-operation discards all tracking. Completions arriving after reset release count as spurious.

## Structure
- A shared pipeline package holds `REG_W` = 5, `NUM_REGS` = 32, the x0 constant, and the `MAX_PENDING` default.
- One sub-module, `sat_counter`: a parameterised saturating incrementer for `stall_cycles`.
- The rest is the busy/count register file plus the combinational hazard logic.

## Test plan
- Long load to x5 issues; next cycle ID reads x5 → `stall_id` = 1 until `cmp_valid` with `cmp_rd` = 5. In that completion cycle `stall_id` = 0 and `issue` = 1, and `pending_cnt` goes 1→0.
- Four long ops to x1..x4 issue (`MAX_PENDING` = 4); a fifth long op to x6 → stalls with `full`. A completion of x2 in a later cycle → the x6 op issues that cycle and `pending_cnt` stays 4.
- A long op to x7 issues while x7 completes in the same cycle (x7 already busy) → no stall; `busy[7]` stays 1 and `pending_cnt` is unchanged.
- An op with rd = x0 and `id_long` = 1 → `busy` stays 0 and `pending_cnt` stays 0. A completion with `cmp_rd` = 0 → `err_spurious` = 1.
- Stall for 3 cycles, then `flush` in cycle 4 → `stall_id` = 0 in cycle 4 and `stall_cycles` = 3. A saturation test with `CNT_W` = 2 holds the counter at 3.
- `rst_n` pulsed low with x9 busy → `busy`, `pending_cnt` and `err_spurious` are 0 immediately, without a clock edge.
